lzc_norm_pipe: RTL

- Parametrised, pipelined leading-digit counter and normaliser for the FP adder datapath.
- Per item, counts the leading zeros (or leading ones, selected per item) of a WIDTH-bit mantissa.
- Left-shifts the mantissa by that count and flags the all-zero / all-one case.
- Two register stages with valid/ready flow control; sits between the mantissa add/subtract and the exponent-adjust/round stage.

---
 rtl/lzc_norm_pipe.sv | 88 ++++++++
 1 files changed

// File: rtl/lzc_norm_pipe.sv
// Leading-zero/one counter and left normaliser: two register stages, item on outputs one edge after input transfer.
// Valid/ready skid-free pipeline: holds 2 items under backpressure, outputs frozen while OUT_READY=0.
module lzc_norm_pipe #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_MODE,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CW-1:0]    OUT_LZ,
  output logic [WIDTH-1:0] OUT_NORM,
  output logic             OUT_ALL,
  output logic [TAG_W-1:0] OUT_TAG
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [CW-1:0]    s1_cnt;
  logic             s1_all;
  logic [TAG_W-1:0] s1_tag;

  logic [CW-1:0]    cnt;
  logic             all_same;
  logic             e1;
  logic             e2;

  // Scan LSB to MSB so the last differing bit seen is the most significant one.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (IN_DATA[i] != IN_MODE) begin
        cnt = CW'(WIDTH - 1 - i);
      end
    end
    all_same = &(IN_DATA ~^ {WIDTH{IN_MODE}});
  end

  always_comb begin
    e2       = s1_valid & (!OUT_VALID | OUT_READY);
    IN_READY = !s1_valid | e2;
    e1       = IN_VALID & IN_READY;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_cnt   <= '0;
      s1_all   <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (e1) begin
        s1_data <= IN_DATA;
        s1_cnt  <= cnt;
        s1_all  <= all_same;
        s1_tag  <= IN_TAG;
      end
      s1_valid <= e1 | (s1_valid & !e2);
    end
  end

  // A shift by WIDTH clears every bit, which is exactly the all-same result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_LZ    <= '0;
      OUT_NORM  <= '0;
      OUT_ALL   <= 1'b0;
      OUT_TAG   <= '0;
    end else begin
      if (e2) begin
        OUT_LZ   <= s1_cnt;
        OUT_NORM <= s1_data << s1_cnt;
        OUT_ALL  <= s1_all;
        OUT_TAG  <= s1_tag;
      end
      OUT_VALID <= e2 | (OUT_VALID & !OUT_READY);
    end
  end

endmodule
